// File: rtl/nibble_serial_adder_if.sv
// Host-side handshake and operand/result bundle for nibble_serial_adder.
// The master modport is the requesting datapath and the slave modport is the adder.
interface nibble_serial_adder_if #(
    parameter int WIDTH = 16
);
    logic             start;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             ci;
    logic [WIDTH-1:0] sum;
    logic             co;
    logic             busy;
    logic             done;

    modport master (
        output start, a, b, ci,
        input  sum, co, busy, done
    );

    modport slave (
        input  start, a, b, ci,
        output sum, co, busy, done
    );
endinterface

// File: rtl/nibble_serial_adder.sv
// Adds two WIDTH-bit operands one nibble per clock through a single external
// 4-bit ripple_adder slice. The carry is chained between nibbles, LSB nibble first.
module nibble_serial_adder #(
    parameter int WIDTH = 16
) (
    input  logic                   clk,
    input  logic                   rst,
    nibble_serial_adder_if.slave   host,
    output logic [3:0]             add_a,
    output logic [3:0]             add_b,
    output logic                   add_ci,
    input  logic [3:0]             add_sum,
    input  logic                   add_co
);
    localparam int NIBBLES = WIDTH / 4;
    localparam int CNT_W   = (NIBBLES > 1) ? $clog2(NIBBLES) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(NIBBLES - 1);

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_RUN  = 2'd1;
    localparam logic [1:0] ST_DONE = 2'd2;

    logic [1:0]       state_r;
    logic [1:0]       state_nxt_s;
    logic [WIDTH-1:0] op_a_r;
    logic [WIDTH-1:0] op_b_r;
    logic [WIDTH-1:0] res_r;
    logic [WIDTH-1:0] res_nxt_s;
    logic [WIDTH+3:0] res_cat_s;
    logic [WIDTH-1:0] sum_r;
    logic [CNT_W-1:0] cnt_r;
    logic             carry_r;
    logic             co_r;
    logic             busy_r;
    logic             done_r;
    logic             last_s;

    // Last-nibble detect and result shift-in (new nibble enters at the top).
    always_comb begin
        last_s    = (cnt_r == CNT_LAST);
        res_cat_s = {add_sum, res_r};
        res_nxt_s = res_cat_s[WIDTH+3:4];
    end

    // Next-state logic; DONE always falls back to IDLE after one cycle.
    always_comb begin
        state_nxt_s = state_r;
        case (state_r)
            ST_IDLE: begin
                if (host.start) begin
                    state_nxt_s = ST_RUN;
                end else begin
                    state_nxt_s = ST_IDLE;
                end
            end
            ST_RUN: begin
                if (last_s) begin
                    state_nxt_s = ST_DONE;
                end else begin
                    state_nxt_s = ST_RUN;
                end
            end
            ST_DONE: state_nxt_s = ST_IDLE;
            default: state_nxt_s = ST_IDLE;
        endcase
    end

    // Slice drive: only RUN presents live operands, otherwise the slice sees zeros.
    always_comb begin
        if (state_r == ST_RUN) begin
            add_a  = op_a_r[3:0];
            add_b  = op_b_r[3:0];
            add_ci = carry_r;
        end else begin
            add_a  = 4'd0;
            add_b  = 4'd0;
            add_ci = 1'b0;
        end
    end

    // State and handshake flags, registered from the next state.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r <= ST_IDLE;
            busy_r  <= 1'b0;
            done_r  <= 1'b0;
        end else begin
            state_r <= state_nxt_s;
            busy_r  <= (state_nxt_s != ST_IDLE);
            done_r  <= (state_nxt_s == ST_DONE);
        end
    end

    // Operand capture, nibble-serial datapath and result publication.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            op_a_r  <= '0;
            op_b_r  <= '0;
            res_r   <= '0;
            sum_r   <= '0;
            cnt_r   <= '0;
            carry_r <= 1'b0;
            co_r    <= 1'b0;
        end else begin
            case (state_r)
                ST_IDLE: begin
                    if (host.start) begin
                        op_a_r  <= host.a;
                        op_b_r  <= host.b;
                        carry_r <= host.ci;
                        res_r   <= '0;
                        cnt_r   <= '0;
                    end else begin
                        op_a_r  <= op_a_r;
                        op_b_r  <= op_b_r;
                    end
                end
                ST_RUN: begin
                    res_r   <= res_nxt_s;
                    carry_r <= add_co;
                    op_a_r  <= op_a_r >> 3'd4;
                    op_b_r  <= op_b_r >> 3'd4;
                    cnt_r   <= cnt_r + CNT_W'(1);
                    // SUM/CO change only here, so the host sees the old result during RUN.
                    if (last_s) begin
                        sum_r <= res_nxt_s;
                        co_r  <= add_co;
                    end else begin
                        sum_r <= sum_r;
                        co_r  <= co_r;
                    end
                end
                default: begin
                    res_r <= res_r;
                end
            endcase
        end
    end

    assign host.sum  = sum_r;
    assign host.co   = co_r;
    assign host.busy = busy_r;
    assign host.done = done_r;
endmodule

// File: tb/tb_nibble_serial_adder.sv
// Directed bench for nibble_serial_adder (WIDTH=16) driving a behavioural 4-bit
// ripple adder slice; every expected value is hand-computed.
module tb_nibble_serial_adder;
    localparam int WIDTH   = 16;
    localparam int NIBBLES = WIDTH / 4;

    logic       clk = 1'b0;
    logic       rst;
    logic [3:0] add_a_s;
    logic [3:0] add_b_s;
    logic [3:0] add_sum_s;
    logic       add_ci_s;
    logic       add_co_s;
    logic [4:0] slice_s;

    int checks = 0;
    int errors = 0;
    int done_cnt;
    logic [15:0] prev_sum;
    logic        prev_co;

    nibble_serial_adder_if #(.WIDTH(WIDTH)) host_if ();

    nibble_serial_adder #(.WIDTH(WIDTH)) dut (
        .clk     (clk),
        .rst     (rst),
        .host    (host_if.slave),
        .add_a   (add_a_s),
        .add_b   (add_b_s),
        .add_ci  (add_ci_s),
        .add_sum (add_sum_s),
        .add_co  (add_co_s)
    );

    // Behavioural ripple_adder slice.
    assign slice_s   = {1'b0, add_a_s} + {1'b0, add_b_s} + {4'd0, add_ci_s};
    assign add_sum_s = slice_s[3:0];
    assign add_co_s  = slice_s[4];

    always #5 clk = ~clk;

    initial begin
        #100000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check_idle_zero(input string tag);
        check({tag, "_sum"},  32'(host_if.sum),  32'h0);
        check({tag, "_co"},   32'(host_if.co),   32'h0);
        check({tag, "_busy"}, 32'(host_if.busy), 32'h0);
        check({tag, "_done"}, 32'(host_if.done), 32'h0);
    endtask

    task automatic run_op(input string tag, input logic [15:0] a, input logic [15:0] b,
                          input logic ci, input logic [15:0] es, input logic eco);
        host_if.a     = a;
        host_if.b     = b;
        host_if.ci    = ci;
        host_if.start = 1'b1;
        step();
        host_if.start = 1'b0;
        host_if.a     = 16'h5A5A;
        host_if.b     = 16'hA5A5;
        host_if.ci    = ~ci;
        check({tag, "_busy0"}, 32'(host_if.busy), 32'h1);
        check({tag, "_done0"}, 32'(host_if.done), 32'h0);
        check({tag, "_adda"},  32'(add_a_s),      32'(a[3:0]));
        check({tag, "_addb"},  32'(add_b_s),      32'(b[3:0]));
        check({tag, "_addci"}, 32'(add_ci_s),     32'(ci));
        for (int i = 0; i < NIBBLES - 1; i++) begin
            step();
            check({tag, "_done_run"}, 32'(host_if.done), 32'h0);
            check({tag, "_hold"},     32'(host_if.sum),  32'(prev_sum));
        end
        step();
        check({tag, "_done"}, 32'(host_if.done), 32'h1);
        check({tag, "_busyd"}, 32'(host_if.busy), 32'h1);
        check({tag, "_sum"},  32'(host_if.sum),  32'(es));
        check({tag, "_co"},   32'(host_if.co),   32'(eco));
        step();
        check({tag, "_done_end"}, 32'(host_if.done), 32'h0);
        check({tag, "_busy_end"}, 32'(host_if.busy), 32'h0);
        check({tag, "_idle_adda"}, 32'(add_a_s), 32'h0);
        prev_sum = es;
        prev_co  = eco;
    endtask

    initial begin
        rst           = 1'b0;
        host_if.start = 1'b0;
        host_if.a     = 16'h0;
        host_if.b     = 16'h0;
        host_if.ci    = 1'b0;
        prev_sum      = 16'h0;
        prev_co       = 1'b0;

        // Reset asserted mid-cycle, before any clock edge.
        #2 rst = 1'b1;
        #1 check_idle_zero("rst_async");
        step();
        rst = 1'b0;
        step();

        run_op("add_small", 16'h0001, 16'h0002, 1'b0, 16'h0003, 1'b0);
        run_op("ripple",    16'hFFFF, 16'h0001, 1'b0, 16'h0000, 1'b1);
        run_op("all_ones",  16'hFFFF, 16'hFFFF, 1'b1, 16'hFFFF, 1'b1);

        // Async reset with a non-zero result held: outputs clear without an edge.
        #3 rst = 1'b1;
        #1 check_idle_zero("rst_mid");
        step();
        rst = 1'b0;
        prev_sum = 16'h0;
        step();

        run_op("zeros", 16'h0000, 16'h0000, 1'b0, 16'h0000, 1'b0);
        run_op("pre_busy", 16'h00FF, 16'h0001, 1'b0, 16'h0100, 1'b0);

        // START re-asserted with new operands during RUN is ignored.
        host_if.a     = 16'h1234;
        host_if.b     = 16'h4321;
        host_if.ci    = 1'b0;
        host_if.start = 1'b1;
        step();
        host_if.a = 16'hFFFF;
        done_cnt  = 0;
        for (int i = 0; i < NIBBLES - 1; i++) begin
            step();
            if (host_if.done) done_cnt++;
        end
        host_if.start = 1'b0;
        for (int i = 0; i < 3; i++) begin
            step();
            if (host_if.done) done_cnt++;
        end
        check("busy_start_dones", 32'(done_cnt), 32'd1);
        check("busy_start_sum",   32'(host_if.sum), 32'h5555);
        check("busy_start_co",    32'(host_if.co),  32'h0);
        check("busy_start_idle",  32'(host_if.busy), 32'h0);
        prev_sum = 16'h5555;

        // Reset during the 2nd RUN cycle abandons the operation.
        host_if.a     = 16'hFFFF;
        host_if.b     = 16'h0001;
        host_if.ci    = 1'b0;
        host_if.start = 1'b1;
        step();
        host_if.start = 1'b0;
        step();
        #2 rst = 1'b1;
        #1 check_idle_zero("rst_run");
        check("rst_run_adda", 32'(add_a_s), 32'h0);
        step();
        rst = 1'b0;
        done_cnt = 0;
        for (int i = 0; i < NIBBLES + 2; i++) begin
            step();
            if (host_if.done) done_cnt++;
        end
        check("rst_run_nodone", 32'(done_cnt), 32'd0);
        check_idle_zero("rst_run_after");
        prev_sum = 16'h0;

        run_op("post_rst", 16'h0FF0, 16'h0010, 1'b1, 16'h1001, 1'b0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
